// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants, scanner state type and helpers for the
//            seg_count_scan counter/display-scanner slice.
// Contents : NUM_DIGITS, DIGIT_MAX, BLANK_CODE, AN_OFF, scan_state_t,
//            an_onehot()
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  // The downstream decoder turns this code into "all segments off".
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {
    DRIVE = 1'b0,
    GAP   = 1'b1
  } scan_state_t;

  // Active-low one-hot digit enable for scan position idx.
  function automatic logic [3:0] an_onehot(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One decade (0..9) counter stage of a ripple-carry BCD chain.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset (q -> 0)
//            clr   - synchronous clear, overrides cin
//            cin   - increment request from the lower stage (or the input)
//            q     - current decade value
//            cout  - combinational carry to the next stage: cin & (q == 9)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (cin) begin
      q_d = (q_q == DIGIT_MAX) ? 4'd0 : (q_q + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign cout = cin & (q_q == DIGIT_MAX);

endmodule : bcd_digit
`default_nettype wire

// File: rtl/seg_count_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_count_scan
// Purpose  : Four-digit BCD event counter (0000..9999) with a time-multiplexed
//            display scanner feeding a BCD-to-seven-segment decoder.
// Params   : REFRESH_DIV - cycles each digit is driven per scan slot (>= 2)
// Ports    : clk       - clock
//            rst_n     - asynchronous active-low reset
//            inc       - count-enable, one increment per sampled cycle
//            clr       - synchronous clear of the count (wins over inc)
//            blank_lz  - blank leading zeros when high
//            count_bcd - current count, [15:12] thousands .. [3:0] units
//            carry     - one-cycle pulse on the 9999 -> 0000 wrap
//            digit     - displayed nibble, BLANK_CODE when blanked / in gap
//            an        - active-low one-hot digit enable, bit 0 = units
// Revision : 1.0 - initial release
// ============================================================================
module seg_count_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  input  logic        blank_lz,
  output logic [15:0] count_bcd,
  output logic        carry,
  output logic [3:0]  digit,
  output logic [3:0]  an
);

  localparam int               PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  // --------------------------------------------------------------------------
  // BCD counter: ripple chain of decade stages, units first.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS:0] carry_chain;
  logic                carry_q;
  logic                carry_d;

  assign carry_chain[0] = inc;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit u_bcd_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .cin   (carry_chain[gi]),
      .q     (count_bcd[4*gi +: 4]),
      .cout  (carry_chain[gi+1])
    );
  end

  // The thousands stage's carry-out is only meaningful when no clear occurs
  // in the same cycle, since the clear also forces every stage to zero.
  assign carry_d = carry_chain[NUM_DIGITS] & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

  // --------------------------------------------------------------------------
  // Scanner FSM: DRIVE for REFRESH_DIV cycles, then a single GAP cycle with
  // every digit off so adjacent digits are never lit together.
  // --------------------------------------------------------------------------
  scan_state_t      state_q;
  logic [1:0]       scan_idx_q;
  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DRIVE;
      scan_idx_q <= 2'd0;
      pre_q      <= '0;
    end else begin
      case (state_q)
        DRIVE: begin
          if (pre_q == PRE_LAST) begin
            state_q <= GAP;
            pre_q   <= '0;
          end else begin
            pre_q   <= pre_q + PRE_W'(1);
          end
        end
        GAP: begin
          state_q    <= DRIVE;
          scan_idx_q <= scan_idx_q + 2'd1;
        end
        default: begin
          state_q    <= DRIVE;
          scan_idx_q <= 2'd0;
          pre_q      <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Blank detection. blank_lz is registered so the display outputs depend
  // only on flops, never combinationally on an input pin.
  // --------------------------------------------------------------------------
  logic                  blank_lz_q;
  logic [NUM_DIGITS-1:0] blank_pos;
  logic                  zero_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_lz_q <= 1'b0;
    end else begin
      blank_lz_q <= blank_lz;
    end
  end

  // Walk from the most significant nibble down: a position is blanked while
  // it and everything above it is zero. The units position always shows.
  always_comb begin
    zero_run  = 1'b1;
    blank_pos = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (count_bcd[4*i +: 4] == 4'd0);
      blank_pos[i] = blank_lz_q & zero_run;
    end
  end

  // --------------------------------------------------------------------------
  // Output mux, decoded from registered state only.
  // --------------------------------------------------------------------------
  always_comb begin
    digit = BLANK_CODE;
    an    = AN_OFF;
    if (state_q == DRIVE) begin
      an    = an_onehot(scan_idx_q);
      digit = blank_pos[scan_idx_q] ? BLANK_CODE
                                    : count_bcd[{scan_idx_q, 2'b00} +: 4];
    end
  end

endmodule : seg_count_scan
`default_nettype wire
